// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: opcodes, one-hot op indices, field bundle.
// Imported by decode_comb and decode_stage.
package rv_decode_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_XOR   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_AND   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_ADDI  = 10;
  localparam int OP_XORI  = 11;
  localparam int OP_ORI   = 12;
  localparam int OP_ANDI  = 13;
  localparam int OP_SLLI  = 14;
  localparam int OP_SRLI  = 15;
  localparam int OP_SRAI  = 16;
  localparam int OP_SLTI  = 17;
  localparam int OP_SLTIU = 18;
  localparam int OP_LB    = 19;
  localparam int OP_LH    = 20;
  localparam int OP_LW    = 21;
  localparam int OP_LBU   = 22;
  localparam int OP_LHU   = 23;
  localparam int OP_SB    = 24;
  localparam int OP_SH    = 25;
  localparam int OP_SW    = 26;
  localparam int OP_BEQ   = 27;
  localparam int OP_BNE   = 28;
  localparam int OP_BLT   = 29;
  localparam int OP_BGE   = 30;
  localparam int OP_BLTU  = 31;
  localparam int OP_BGEU  = 32;
  localparam int OP_JAL   = 33;
  localparam int OP_JALR  = 34;
  localparam int OP_LUI   = 35;
  localparam int OP_AUIPC = 36;
  localparam int OP_MUL   = 37;
  localparam int OP_REMU  = 44;

  localparam int OP_W_BASE = 37;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_valid;
    logic       rs2_valid;
    logic       rd_valid;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(+M) decoder: instr -> fields, imm, one-hot op.
// Ports: instr in; fields, imm (XLEN, sign-extended), op (OP_W) out.
module decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 0,
  localparam int OP_W = OP_W_BASE + 8 * EN_M
) (
  input  logic [31:0]     instr,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm,
  output logic [OP_W-1:0] op
);

  localparam logic [OP_W-1:0] ONE = 1;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic        sh_ok;
  logic        is_r, is_i, is_ld, is_jalr;
  logic        is_s, is_b, is_jal, is_lui, is_auipc;
  logic        has_rs1, has_rs2, has_rd;
  logic [31:0] imm32;
  int          sel;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign f6  = instr[31:26];

  // shamt[5] only exists on RV64
  assign sh_ok = (XLEN == 64) || !instr[25];

  assign is_r     = opc == OPC_R;
  assign is_i     = opc == OPC_I;
  assign is_ld    = opc == OPC_LOAD;
  assign is_jalr  = opc == OPC_JALR;
  assign is_s     = opc == OPC_S;
  assign is_b     = opc == OPC_B;
  assign is_jal   = opc == OPC_JAL;
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;

  always_comb begin
    sel = -1;
    unique case (1'b1)
      is_r: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: sel = OP_ADD;
            3'd1: sel = OP_SLL;
            3'd2: sel = OP_SLT;
            3'd3: sel = OP_SLTU;
            3'd4: sel = OP_XOR;
            3'd5: sel = OP_SRL;
            3'd6: sel = OP_OR;
            3'd7: sel = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0) sel = OP_SUB;
          else if (f3 == 3'd5) sel = OP_SRA;
        end else if (EN_M != 0 && f7 == 7'b0000001) begin
          sel = OP_MUL + int'(f3);
        end
      end
      is_i: begin
        case (f3)
          3'd0: sel = OP_ADDI;
          3'd2: sel = OP_SLTI;
          3'd3: sel = OP_SLTIU;
          3'd4: sel = OP_XORI;
          3'd6: sel = OP_ORI;
          3'd7: sel = OP_ANDI;
          3'd1: if (f6 == 6'b0 && sh_ok) sel = OP_SLLI;
          3'd5: begin
            if (sh_ok && f6 == 6'b000000) sel = OP_SRLI;
            else if (sh_ok && f6 == 6'b010000) sel = OP_SRAI;
          end
        endcase
      end
      is_ld: begin
        case (f3)
          3'd0: sel = OP_LB;
          3'd1: sel = OP_LH;
          3'd2: sel = OP_LW;
          3'd4: sel = OP_LBU;
          3'd5: sel = OP_LHU;
          default: ;
        endcase
      end
      is_s: begin
        case (f3)
          3'd0: sel = OP_SB;
          3'd1: sel = OP_SH;
          3'd2: sel = OP_SW;
          default: ;
        endcase
      end
      is_b: begin
        case (f3)
          3'd0: sel = OP_BEQ;
          3'd1: sel = OP_BNE;
          3'd4: sel = OP_BLT;
          3'd5: sel = OP_BGE;
          3'd6: sel = OP_BLTU;
          3'd7: sel = OP_BGEU;
          default: ;
        endcase
      end
      is_jalr:  if (f3 == 3'd0) sel = OP_JALR;
      is_jal:   sel = OP_JAL;
      is_lui:   sel = OP_LUI;
      is_auipc: sel = OP_AUIPC;
      default: ;
    endcase
  end

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_i, is_ld, is_jalr:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      is_s:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      is_b:
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      is_jal:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
      is_lui, is_auipc:
        imm32 = {instr[31:12], 12'b0};
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
  assign op  = (sel >= 0) ? (ONE << sel) : '0;

  assign has_rs1 = is_r | is_i | is_ld | is_jalr | is_s | is_b;
  assign has_rs2 = is_r | is_s | is_b;
  assign has_rd  = is_r | is_i | is_ld | is_jalr
                 | is_jal | is_lui | is_auipc;

  always_comb begin
    fields.illegal   = sel < 0;
    fields.rs1_valid = has_rs1;
    fields.rs2_valid = has_rs2;
    fields.rd_valid  = has_rd && !fields.illegal;
    fields.rs1 = has_rs1 ? instr[19:15] : 5'd0;
    fields.rs2 = has_rs2 ? instr[24:20] : 5'd0;
    fields.rd  = fields.rd_valid ? instr[11:7] : 5'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with 2-entry skid buffer and flush.
// Ports: fetch in_* (valid/ready), execute out_* (valid/ready), flush.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 0,
  localparam int OP_W = OP_W_BASE + 8 * EN_M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_valid,
  output logic            out_rs2_valid,
  output logic            out_rd_valid,
  output logic [XLEN-1:0] out_imm,
  output logic [OP_W-1:0] out_op,
  output logic            out_illegal
);

  dec_fields_t     dec_f, main_f, skid_f;
  logic [XLEN-1:0] dec_imm, main_imm, skid_imm;
  logic [OP_W-1:0] dec_op, main_op, skid_op;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic            main_v, skid_v;
  logic            acc;

  decode_comb #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_dec (
    .instr  (in_instr),
    .fields (dec_f),
    .imm    (dec_imm),
    .op     (dec_op)
  );

  assign in_ready = !skid_v;
  assign acc      = in_valid && !skid_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_f   <= '0;
      skid_f   <= '0;
      main_imm <= '0;
      skid_imm <= '0;
      main_op  <= '0;
      skid_op  <= '0;
      main_pc  <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // main is free this edge: skid drains first to keep FIFO order
      main_v <= skid_v || acc;
      if (skid_v) begin
        skid_v   <= 1'b0;
        main_f   <= skid_f;
        main_imm <= skid_imm;
        main_op  <= skid_op;
        main_pc  <= skid_pc;
      end else if (acc) begin
        main_f   <= dec_f;
        main_imm <= dec_imm;
        main_op  <= dec_op;
        main_pc  <= in_pc;
      end
    end else if (acc) begin
      skid_v   <= 1'b1;
      skid_f   <= dec_f;
      skid_imm <= dec_imm;
      skid_op  <= dec_op;
      skid_pc  <= in_pc;
    end
  end

  assign out_valid     = main_v;
  assign out_pc        = main_pc;
  assign out_rs1       = main_f.rs1;
  assign out_rs2       = main_f.rs2;
  assign out_rd        = main_f.rd;
  assign out_rs1_valid = main_f.rs1_valid;
  assign out_rs2_valid = main_f.rs2_valid;
  assign out_rd_valid  = main_f.rd_valid;
  assign out_imm       = main_imm;
  assign out_op        = main_op;
  assign out_illegal   = main_f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: EN_M=0 and EN_M=1 instances, shared stimulus.
// Scoreboard queue filled on accept, drained by an output monitor.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, o0_valid;
  logic [31:0] o0_pc, o0_imm;
  logic [4:0]  o0_rs1, o0_rs2, o0_rd;
  logic        o0_rs1_v, o0_rs2_v, o0_rd_v, o0_ill;
  logic [36:0] o0_op;

  logic        in_ready1, o1_valid;
  logic [31:0] o1_pc, o1_imm;
  logic [4:0]  o1_rs1, o1_rs2, o1_rd;
  logic        o1_rs1_v, o1_rs2_v, o1_rd_v, o1_ill;
  logic [44:0] o1_op;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_M(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o0_valid), .out_ready(out_ready),
    .out_pc(o0_pc), .out_rs1(o0_rs1), .out_rs2(o0_rs2),
    .out_rd(o0_rd), .out_rs1_valid(o0_rs1_v),
    .out_rs2_valid(o0_rs2_v), .out_rd_valid(o0_rd_v),
    .out_imm(o0_imm), .out_op(o0_op), .out_illegal(o0_ill)
  );

  decode_stage #(.XLEN(32), .EN_M(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o1_valid), .out_ready(out_ready),
    .out_pc(o1_pc), .out_rs1(o1_rs1), .out_rs2(o1_rs2),
    .out_rd(o1_rd), .out_rs1_valid(o1_rs1_v),
    .out_rs2_valid(o1_rs2_v), .out_rd_valid(o1_rd_v),
    .out_imm(o1_imm), .out_op(o1_op), .out_illegal(o1_ill)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  v;
    logic [31:0] imm;
    logic [36:0] op0;
    logic        ill0;
    logic [44:0] op1;
    logic        ill1;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(
    input logic [31:0] pc,
    input logic [4:0]  rs1, rs2, rd,
    input logic [2:0]  v,
    input logic [31:0] imm,
    input int          b0, b1
  );
    exp_t e;
    logic [36:0] one0;
    logic [44:0] one1;
    one0 = 37'd1;
    one1 = 45'd1;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.v = v; e.imm = imm;
    e.op0  = (b0 >= 0) ? (one0 << b0) : '0;
    e.ill0 = b0 < 0;
    e.op1  = (b1 >= 0) ? (one1 << b1) : '0;
    e.ill1 = b1 < 0;
    return e;
  endfunction

  function automatic logic [31:0] addi_instr(input logic [11:0] k);
    return {k, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic exp_t addi_exp(
    input logic [31:0] pc, input logic [11:0] k
  );
    return mk(pc, 0, 0, 1, 3'b101, {{20{k[11]}}, k}, 10, 10);
  endfunction

  // output monitor: every handshake pops and checks one entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && o0_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out pc=%h op=%h", o0_pc, o0_op);
      end else begin
        e = q.pop_front();
        if (e.ill0) begin
          if ({o0_pc, o0_op, o0_ill, o0_rd_v}
              !== {e.pc, 37'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL illegal_entry pc=%h got op=%h ill=%b rdv=%b req op=0 ill=1 rdv=0",
                     o0_pc, o0_op, o0_ill, o0_rd_v);
          end
        end else if ({o0_pc, o0_rs1, o0_rs2, o0_rd,
                      o0_rs1_v, o0_rs2_v, o0_rd_v,
                      o0_imm, o0_op, o0_ill}
                     !== {e.pc, e.rs1, e.rs2, e.rd, e.v,
                          e.imm, e.op0, 1'b0}) begin
          errors++;
          $display("FAIL entry pc=%h got rs=%0d/%0d/%0d v=%b imm=%h op=%h ill=%b req pc=%h rs=%0d/%0d/%0d v=%b imm=%h op=%h",
                   o0_pc, o0_rs1, o0_rs2, o0_rd,
                   {o0_rs1_v, o0_rs2_v, o0_rd_v}, o0_imm, o0_op, o0_ill,
                   e.pc, e.rs1, e.rs2, e.rd, e.v, e.imm, e.op0);
        end
        checks++;
        if ({o1_valid, o1_pc, o1_op, o1_ill}
            !== {1'b1, e.pc, e.op1, e.ill1}) begin
          errors++;
          $display("FAIL m_entry pc=%h got op=%h ill=%b req op=%h ill=%b",
                   o1_pc, o1_op, o1_ill, e.op1, e.ill1);
        end
      end
    end
  end

  task automatic tick();
    if (in_valid && in_ready && !flush) q.push_back(cur);
    @(posedge clk);
    #1;
    if (flush) q.delete();
  endtask

  task automatic send(input exp_t e, input logic [31:0] instr);
    bit ok;
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = e.pc;
    cur = e;
    for (int n = 0; n < 20 && !done; n++) begin
      ok = in_ready;
      tick();
      if (ok) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=%h in_ready=%b req 1", e.pc, in_ready);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d req 0", q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({o0_valid, in_ready, o0_op, o0_ill, o0_pc, o0_imm, o0_rd_v}
        !== {1'b0, 1'b1, 37'b0, 1'b0, 32'b0, 32'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b op=%h ill=%b req v=0 rdy=1 op=0 ill=0",
               o0_valid, in_ready, o0_op, o0_ill);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    send(mk(32'h100, 1, 2, 3, 3'b111, 0, 0, 0), 32'h002081B3);
    checks++;
    if ({o0_valid, o0_rd} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL add_latency got v=%b rd=%0d req v=1 rd=3", o0_valid, o0_rd);
    end
    send(mk(32'h104, 2, 0, 1, 3'b101, 32'h403, 16, 16), 32'h40315093);
    send(mk(32'h108, 0, 0, 5, 3'b101, 32'hFFFFFFFF, 10, 10), 32'hFFF00293);
    drain();
  endtask

  task automatic test_mem_branch();
    send(mk(32'h200, 1, 2, 0, 3'b110, 8, 26, 26), 32'h0020A423);
    send(mk(32'h204, 1, 2, 0, 3'b110, 32'hFFFFFFFC, 27, 27), 32'hFE208EE3);
    send(mk(32'h208, 1, 0, 3, 3'b101, 4, 21, 21), 32'h0040A183);
    drain();
  endtask

  task automatic test_upper_jump();
    send(mk(32'h300, 0, 0, 5, 3'b001, 32'h12345000, 35, 35), 32'h123452B7);
    send(mk(32'h304, 0, 0, 1, 3'b001, 8, 33, 33), 32'h008000EF);
    drain();
  endtask

  task automatic test_illegal();
    send(mk(32'h400, 0, 0, 0, 3'b000, 0, -1, -1), 32'hFFFFFFFF);
    send(mk(32'h404, 1, 2, 0, 3'b110, 0, -1, 37), 32'h022081B3);
    send(mk(32'h408, 1, 0, 0, 3'b100, 32, -1, -1), 32'h02009093);
    drain();
  endtask

  task automatic test_m_ext();
    send(mk(32'h500, 1, 2, 0, 3'b110, 0, -1, 41), 32'h0220C1B3);
    send(mk(32'h504, 1, 2, 0, 3'b110, 0, -1, 43), 32'h0220E1B3);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = addi_instr(12'(i + 1));
      in_pc = 32'h600 + 32'(i * 4);
      cur = addi_exp(in_pc, 12'(i + 1));
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready i=%0d got %b req 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({o0_valid, o0_pc} !== {1'b1, 32'h614}) begin
      errors++;
      $display("FAIL b2b_last got v=%b pc=%h req v=1 pc=00000614", o0_valid, o0_pc);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(addi_exp(32'h700, 12'd21), addi_instr(12'd21));
    send(addi_exp(32'h704, 12'd22), addi_instr(12'd22));
    checks++;
    if ({in_ready, o0_valid, o0_pc} !== {1'b0, 1'b1, 32'h700}) begin
      errors++;
      $display("FAIL bp_full got rdy=%b v=%b pc=%h req rdy=0 v=1 pc=00000700",
               in_ready, o0_valid, o0_pc);
    end
    in_valid = 1'b1;
    in_instr = addi_instr(12'd23);
    in_pc = 32'h708;
    cur = addi_exp(32'h708, 12'd23);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({in_ready, o0_pc} !== {1'b0, 32'h700}) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b pc=%h req rdy=0 pc=00000700", in_ready, o0_pc);
    end
    out_ready = 1'b1;
    send(addi_exp(32'h708, 12'd23), addi_instr(12'd23));
    send(addi_exp(32'h70C, 12'd24), addi_instr(12'd24));
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(addi_exp(32'h800, 12'd31), addi_instr(12'd31));
    send(addi_exp(32'h804, 12'd32), addi_instr(12'd32));
    in_valid = 1'b1;
    in_instr = addi_instr(12'd33);
    in_pc = 32'h808;
    cur = addi_exp(32'h808, 12'd33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({o0_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_state got v=%b rdy=%b req v=0 rdy=1", o0_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    send(addi_exp(32'h80C, 12'd34), addi_instr(12'd34));
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(addi_exp(32'h900, 12'd41), addi_instr(12'd41));
    checks++;
    if (o0_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got v=%b req 1", o0_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o0_valid, in_ready, o0_op} !== {1'b0, 1'b1, 37'b0}) begin
      errors++;
      $display("FAIL areset_clear got v=%b rdy=%b op=%h req v=0 rdy=1 op=0",
               o0_valid, in_ready, o0_op);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(addi_exp(32'h904, 12'd42), addi_instr(12'd42));
    drain();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_branch();
    test_upper_jump();
    test_illegal();
    test_m_ext();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
